truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Upstream stimulus and downstream response stage for the team's 10-input, single-output combinational benchmark circuits, such as the D-reduction projection netlists.
- Drives every input minterm 0..2^N_IN-1 into the combinational DUT in ascending order and samples its output in the same cycle.
- Produces an on-set count, a serial signature, and a stream of on-set minterms with valid/ready handshake.
- Used to check optimized netlists for equivalence against their originals.

Parameters:
- N_IN, 10, number of DUT inputs; x_out[i] drives DUT input xi.
- SIG_W, 16, signature register width.
- SIG_POLY, 16'h1021, feedback polynomial; taps exclude the implicit x^SIG_W term.
- SIG_SEED, 16'hFFFF, signature value after reset and on every start.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a sweep; sampled only in IDLE and DONE.
- x_out  out  N_IN  current minterm applied to the DUT.
- y_in  in  1  DUT output; combinational function of x_out.
- busy  out  1  high while in SWEEP.
- done  out  1  high in DONE; held until the next start or rst.
- ones_count  out  N_IN+1  number of accepted minterms with y_in=1.
- signature  out  SIG_W  serial signature of the y_in sequence.
- onset_valid  out  1  on-set minterm available.
- onset_ready  in  1  consumer accepts the on-set minterm.
- onset_minterm  out  N_IN  on-set minterm value; equals x_out.

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-sweep):
  - state=IDLE, x_out=0, busy=0, done=0, ones_count=0, signature=SIG_SEED.
  - onset_valid is 0 whenever the state is not SWEEP.
- States: IDLE, SWEEP, DONE.
- IDLE or DONE with start=1: next state SWEEP; x_out=0, ones_count=0, signature=SIG_SEED, done=0.
- SWEEP is the only state with this timing:
  - onset_valid = y_in (combinational).
  - onset_minterm = x_out.
  - accept = ~(y_in & ~onset_ready).
- Stall (y_in=1 and onset_ready=0):
  - x_out, ones_count and signature hold.
  - onset_valid and onset_minterm stay stable until the handshake completes.
- Each accept cycle:
  - ones_count += y_in.
  - fb = signature[SIG_W-1] ^ y_in.
  - signature = (signature<<1) ^ (fb ? SIG_POLY : 0).
  - If x_out = 2^N_IN-1: next state DONE, x_out holds at 2^N_IN-1. Otherwise x_out += 1.
- start during SWEEP is ignored.
- Latency:
  - Start sampled at edge k puts the block in SWEEP from cycle k+1.
  - With no stalls, busy is high for exactly 2^N_IN cycles and done rises at cycle k+1+2^N_IN.
  - Each stall cycle adds exactly one cycle.
- Width rules:
  - ones_count reaches 2^N_IN at most, so N_IN+1 bits never overflow.
  - The x_out increment never wraps, because the last minterm transitions to DONE.
- Outputs in DONE hold final values until start or rst.
- start=1 in DONE restarts immediately with a fresh seed and count.

Test Plan:
- DUT y=0, onset_ready=1, start pulse at cycle 0:
  - busy high cycles 1..1024; done=1 at cycle 1025.
  - ones_count=0; onset_valid never asserts.
  - signature equals the reference model's value for 1024 zero bits from 16'hFFFF.
- DUT y=x0, onset_ready=1:
  - ones_count=512; onset_minterm sequence 1,3,5,…,1023.
  - done at cycle 1025.
- DUT y=&x (AND of all inputs):
  - ones_count=1; single onset_valid with minterm 1023, in the last SWEEP cycle.
- DUT y=1, onset_ready low on alternate cycles:
  - ones_count=1024; every minterm delivered exactly once, in order.
  - onset_minterm stable during each stall; busy lasts 1024 + number of stall cycles.
- rst asserted at minterm 300 mid-sweep:
  - next cycle IDLE, x_out=0, ones_count=0, signature=16'hFFFF, busy=0.
  - A subsequent start produces full-sweep results identical to a clean run.
- start held high throughout, including during SWEEP and into DONE:
  - No restart during the sweep.
  - done visible for exactly one cycle, then a new sweep begins with the counters cleared.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive minterm sweeper for a 10-input combinational DUT: counts the on-set, builds an LFSR signature, streams on-set minterms.
// Latency: SWEEP one cycle after start, 2^N_IN cycles plus stalls; a held on-set minterm stalls the sweep until onset_ready.
module truth_table_sweeper #(
    parameter int                N_IN     = 10,
    parameter int                SIG_W    = 16,
    parameter logic [SIG_W-1:0]  SIG_POLY = 16'h1021,
    parameter logic [SIG_W-1:0]  SIG_SEED = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   x_out,
    input  logic              y_in,
    output logic              busy,
    output logic              done,
    output logic [N_IN:0]     ones_count,
    output logic [SIG_W-1:0]  signature,
    output logic              onset_valid,
    input  logic              onset_ready,
    output logic [N_IN-1:0]   onset_minterm
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam logic [N_IN-1:0] X_LAST = '1;
    localparam logic [N_IN-1:0] X_ONE  = {{(N_IN-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [N_IN-1:0]    x_q, x_d;
    logic [N_IN:0]      ones_q, ones_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic               accept;
    logic               fb;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        ones_d  = ones_q;
        sig_d   = sig_q;
        // an on-set minterm nobody takes freezes the sweep in place
        accept  = ~(y_in & ~onset_ready);
        fb      = sig_q[SIG_W-1] ^ y_in;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SWEEP;
                    x_d     = '0;
                    ones_d  = '0;
                    sig_d   = SIG_SEED;
                end
            end
            SWEEP: begin
                if (accept) begin
                    ones_d = ones_q + {{N_IN{1'b0}}, y_in};
                    sig_d  = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : '0);
                    if (x_q == X_LAST) begin
                        state_d = DONE;
                    end else begin
                        x_d = x_q + X_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            ones_q  <= '0;
            sig_q   <= SIG_SEED;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            ones_q  <= ones_d;
            sig_q   <= sig_d;
        end
    end

    assign x_out         = x_q;
    assign busy          = (state_q == SWEEP);
    assign done          = (state_q == DONE);
    assign ones_count    = ones_q;
    assign signature     = sig_q;
    assign onset_valid   = (state_q == SWEEP) & y_in;
    assign onset_minterm = x_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: table of full sweeps over several DUT functions plus reset and held-start sequences.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  x_out;
    logic        y_in;
    logic        busy;
    logic        done;
    logic [10:0] ones_count;
    logic [15:0] signature;
    logic        onset_valid;
    logic        onset_ready;
    logic [9:0]  onset_minterm;

    int checks = 0;
    int failures = 0;
    int mode = 0;

    always #5 clk = ~clk;

    truth_table_sweeper dut (
        .clk(clk), .rst(rst), .start(start), .x_out(x_out), .y_in(y_in),
        .busy(busy), .done(done), .ones_count(ones_count), .signature(signature),
        .onset_valid(onset_valid), .onset_ready(onset_ready), .onset_minterm(onset_minterm)
    );

    // functions under test: 0 const0, 1 x0, 2 AND of all, 3 const1, 4 parity
    function automatic logic fn(int md, logic [9:0] m);
        case (md)
            0:       return 1'b0;
            1:       return m[0];
            2:       return &m;
            3:       return 1'b1;
            default: return ^m;
        endcase
    endfunction

    always_comb y_in = fn(mode, x_out);

    function automatic logic [15:0] ref_sig(int md);
        logic [15:0] s;
        logic        f;
        s = 16'hFFFF;
        for (int m = 0; m < 1024; m++) begin
            f = s[15] ^ fn(md, m[9:0]);
            s = {s[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
        end
        return s;
    endfunction

    function automatic int next_on(int md, int from);
        for (int m = from; m < 1024; m++)
            if (fn(md, m[9:0])) return m;
        return 1024;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        int md;
        int rdy_alt;
        int exp_ones;
    } vec_t;

    // Full sweep from a start pulse; checks timing, stream order, stall stability and final results.
    task automatic run_sweep(int md, int rdy_alt, int exp_ones);
        int cyc = 0, busy_cnt = 0, stalls = 0, done_cyc = -1, hs = 0;
        int exp_min, order_err = 0, stab_err = 0, first_busy = 0;
        logic prev_stall = 1'b0;
        logic [9:0] prev_min = '0;
        mode = md;
        exp_min = next_on(md, 0);
        @(negedge clk);
        start = 1'b1;
        onset_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (1) begin
            cyc++;
            if (cyc > 1) onset_ready = rdy_alt ? ~onset_ready : 1'b1;
            #1;
            if (cyc == 1) first_busy = busy;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy) busy_cnt++;
            if (prev_stall && (!onset_valid || onset_minterm != prev_min)) stab_err++;
            prev_stall = 1'b0;
            if (onset_valid) begin
                if (onset_ready) begin
                    if (onset_minterm != exp_min[9:0]) order_err++;
                    hs++;
                    exp_min = next_on(md, exp_min + 1);
                end else begin
                    stalls++;
                    prev_stall = 1'b1;
                    prev_min = onset_minterm;
                end
            end
            if (cyc > 4000) break;
            @(negedge clk);
        end
        chk($sformatf("busy_at_first_cycle m%0d", md), first_busy, 1);
        chk($sformatf("done_cycle m%0d", md), done_cyc, 1025 + stalls);
        chk($sformatf("busy_cycles m%0d", md), busy_cnt, 1024 + stalls);
        chk($sformatf("ones_count m%0d", md), ones_count, exp_ones);
        chk($sformatf("handshakes m%0d", md), hs, exp_ones);
        chk($sformatf("minterm_order_errs m%0d", md), order_err, 0);
        chk($sformatf("stall_stability_errs m%0d", md), stab_err, 0);
        chk($sformatf("signature m%0d", md), signature, ref_sig(md));
        chk($sformatf("x_out_final m%0d", md), x_out, 1023);
        if (rdy_alt) chk($sformatf("stalls_seen m%0d", md), (stalls > 0) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        #1;
        chk($sformatf("done_hold m%0d", md), {done, busy, onset_valid}, 3'b100);
        chk($sformatf("ones_hold m%0d", md), ones_count, exp_ones);
    endtask

    initial begin
        vec_t vecs[5];
        int n;
        vecs[0] = '{0, 0, 0};
        vecs[1] = '{1, 0, 512};
        vecs[2] = '{2, 0, 1};
        vecs[3] = '{3, 1, 1024};
        vecs[4] = '{4, 1, 512};

        rst = 1'b1; start = 1'b0; onset_ready = 1'b1; mode = 3;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_x_out", x_out, 0);
        chk("reset_flags", {busy, done, onset_valid}, 0);
        chk("reset_ones", ones_count, 0);
        chk("reset_signature", signature, 16'hFFFF);
        rst = 1'b0;

        foreach (vecs[i]) run_sweep(vecs[i].md, vecs[i].rdy_alt, vecs[i].exp_ones);

        // reset in the middle of a sweep
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (x_out != 10'd300 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_minterm_300", x_out, 300);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_x_out", x_out, 0);
        chk("midrst_ones", ones_count, 0);
        chk("midrst_signature", signature, 16'hFFFF);
        chk("midrst_flags", {busy, done, onset_valid}, 0);
        run_sweep(1, 0, 512);

        // start held high: no restart in SWEEP, DONE lasts exactly one cycle
        mode = 1;
        onset_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        n = 0;
        @(negedge clk);
        #1;
        while (!done && n < 3000) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("held_busy_cycles", n, 1024);
        chk("held_done_ones", ones_count, 512);
        @(negedge clk);
        #1;
        chk("held_restart_flags", {busy, done}, 2'b10);
        chk("held_restart_x_out", x_out, 0);
        chk("held_restart_ones", ones_count, 0);
        chk("held_restart_signature", signature, 16'hFFFF);
        start = 1'b0;
        n = 0;
        while (!done && n < 3000) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("held_second_ones", ones_count, 512);
        chk("held_second_signature", signature, ref_sig(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
